alu_sequencer: RTL and testbench

Issue-side controller for the 64-bit datapath ALU. It accepts LEGv8 R-format operation requests over a valid/ready handshake and decodes the 11-bit opcode into the ALU's 4-bit ALUControl code. It drives the ALU's operand inputs and captures the result and zero flag, returning them over a valid/ready response port. MUL has no ALU code of its own, so the block performs it iteratively: 64 shift-and-add passes, each using the ALU's add operation.

---
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-side signals of the ALU issue sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_opcode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  ALUControl;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_result, alu_zero, rsp_ready,
    output req_ready, ALUControl, alu_a, alu_b, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_result, alu_zero, rsp_ready,
    input  req_ready, ALUControl, alu_a, alu_b, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue-side controller for the 64-bit ALU: decodes LEGv8 R-format ops into ALUControl.
// Define ALU_SEQ_MUL_EN to enable the iterative 64-pass shift-and-add MUL.
module alu_sequencer (
  input logic           clk,
  input logic           reset,
  alu_sequencer_if.slave bus
);
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlIdle = 4'b1111;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

  state_e      state_q;
  logic        req_ready_q, rsp_valid_q, rsp_zero_q, rsp_illegal_q;
  logic [3:0]  ctrl_q;
  logic [63:0] alu_a_q, alu_b_q, rsp_result_q;

  logic        dec_legal;
  logic [3:0]  dec_code;
`ifdef ALU_SEQ_MUL_EN
  logic        dec_mul;
  logic [63:0] mcand_q, mplier_q;
  logic [5:0]  count_q;
`endif

  always_comb begin
    dec_legal = 1'b1;
    dec_code  = CtrlIdle;
`ifdef ALU_SEQ_MUL_EN
    dec_mul   = 1'b0;
`endif
    case (bus.req_opcode)
      11'b10001011000: dec_code = 4'b0010;
      11'b11001011000: dec_code = 4'b0110;
      11'b10001010000: dec_code = 4'b0000;
      11'b10101010000: dec_code = 4'b0001;
      11'b11010010100: dec_code = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
      11'b10011011000: dec_mul  = 1'b1;
`endif
      default:         dec_legal = 1'b0;
    endcase
  end

  // alu_a_q doubles as the MUL accumulator; alu_b_q is preloaded with the next partial product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_result_q  <= '0;
      ctrl_q        <= CtrlIdle;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q       <= '0;
      mplier_q      <= '0;
      count_q       <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            if (!dec_legal) begin
              state_q       <= StResp;
              rsp_valid_q   <= 1'b1;
              rsp_result_q  <= '0;
              rsp_zero_q    <= 1'b1;
              rsp_illegal_q <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            end else if (dec_mul) begin
              state_q  <= StMul;
              ctrl_q   <= CtrlAdd;
              alu_a_q  <= '0;
              alu_b_q  <= bus.req_b[0] ? bus.req_a : '0;
              mcand_q  <= bus.req_a;
              mplier_q <= bus.req_b;
              count_q  <= '0;
`endif
            end else begin
              state_q <= StExec;
              ctrl_q  <= dec_code;
              alu_a_q <= bus.req_a;
              alu_b_q <= bus.req_b;
            end
          end
        end
        StExec: begin
          state_q       <= StResp;
          rsp_valid_q   <= 1'b1;
          rsp_result_q  <= bus.alu_result;
          rsp_zero_q    <= bus.alu_zero;
          rsp_illegal_q <= 1'b0;
          ctrl_q        <= CtrlIdle;
          alu_a_q       <= '0;
          alu_b_q       <= '0;
        end
`ifdef ALU_SEQ_MUL_EN
        StMul: begin
          count_q  <= count_q + 6'd1;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (count_q == 6'd63) begin
            state_q       <= StResp;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= bus.alu_result;
            rsp_zero_q    <= bus.alu_zero;
            rsp_illegal_q <= 1'b0;
            ctrl_q        <= CtrlIdle;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
          end else begin
            alu_a_q <= bus.alu_result;
            alu_b_q <= mplier_q[1] ? (mcand_q << 1) : '0;
          end
        end
`endif
        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.ALUControl  = ctrl_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural combinational ALU attached.
// Honors ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_sequencer;
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpMovz = 11'b11010010100;
  localparam logic [10:0] OpMul  = 11'b10011011000;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    logic [3:0]  ctrl;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  alu_sequencer_if bus_if ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus_if.alu_result = '0;
    case (bus_if.ALUControl)
      4'b0000: bus_if.alu_result = bus_if.alu_a & bus_if.alu_b;
      4'b0001: bus_if.alu_result = bus_if.alu_a | bus_if.alu_b;
      4'b0010: bus_if.alu_result = bus_if.alu_a + bus_if.alu_b;
      4'b0110: bus_if.alu_result = bus_if.alu_a - bus_if.alu_b;
      4'b0111: bus_if.alu_result = bus_if.alu_b;
      default: bus_if.alu_result = '0;
    endcase
    bus_if.alu_zero = (bus_if.alu_result == 64'd0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [10:0] op, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t e;
    e.ill  = 1'b0;
    e.lat  = 1;
    e.res  = '0;
    e.ctrl = 4'b1111;
    case (op)
      OpAdd:  begin e.res = a + b; e.ctrl = 4'b0010; end
      OpSub:  begin e.res = a - b; e.ctrl = 4'b0110; end
      OpAnd:  begin e.res = a & b; e.ctrl = 4'b0000; end
      OpOrr:  begin e.res = a | b; e.ctrl = 4'b0001; end
      OpMovz: begin e.res = b;     e.ctrl = 4'b0111; end
`ifdef ALU_SEQ_MUL_EN
      OpMul:  begin e.res = a * b; e.ctrl = 4'b0010; e.lat = 64; end
`endif
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.res = '0;
      e.lat = 0;
    end
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  // Drive one request; returns after the accept edge (+1 time unit).
  task automatic issue(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!bus_if.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {63'd0, bus_if.req_ready}, 64'd1);
    bus_if.req_valid  = 1'b1;
    bus_if.req_opcode = op;
    bus_if.req_a      = a;
    bus_if.req_b      = b;
    e = model(op, a, b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    check("ctrl_after_accept", {60'd0, bus_if.ALUControl}, {60'd0, e.ctrl});
    check("req_ready_busy", {63'd0, bus_if.req_ready}, 64'd0);
  endtask

  // Wait for the response, compare with the scoreboard head, hold backpressure, then consume.
  task automatic collect(input int hold);
    exp_t        e;
    int          lat;
    logic [63:0] res0;
    lat = 0;
    while (!bus_if.rsp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check("rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd1);
    check("latency", 64'(lat), 64'(e.lat));
    check("rsp_result", bus_if.rsp_result, e.res);
    check("rsp_zero", {63'd0, bus_if.rsp_zero}, {63'd0, e.zero});
    check("rsp_illegal", {63'd0, bus_if.rsp_illegal}, {63'd0, e.ill});
    res0 = bus_if.rsp_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {63'd0, bus_if.rsp_valid}, 64'd1);
      check("bp_result", bus_if.rsp_result, res0);
      check("bp_req_ready", {63'd0, bus_if.req_ready}, 64'd0);
    end
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rsp_ready = 1'b0;
    check("consumed_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    check("idle_req_ready", {63'd0, bus_if.req_ready}, 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", {63'd0, bus_if.req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    check("rst_rsp_illegal", {63'd0, bus_if.rsp_illegal}, 64'd0);
    check("rst_ctrl", {60'd0, bus_if.ALUControl}, 64'hF);
    check("rst_rsp_result", bus_if.rsp_result, 64'd0);
    check("rst_rsp_zero", {63'd0, bus_if.rsp_zero}, 64'd0);
    check("rst_alu_a", bus_if.alu_a, 64'd0);
    check("rst_alu_b", bus_if.alu_b, 64'd0);
  endtask

  initial begin
    bus_if.req_valid  = 1'b0;
    bus_if.req_opcode = '0;
    bus_if.req_a      = '0;
    bus_if.req_b      = '0;
    bus_if.rsp_ready  = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    issue(OpAdd, 64'd5, 64'd7);           collect(0);
    issue(OpSub, 64'h1234, 64'h1234);     collect(0);
    issue(OpOrr, 64'hF0, 64'h0F);         collect(0);
    issue(OpAnd, 64'hFF00_FF00_1234_5678, 64'h0FF0_0FF0_FFFF_0000); collect(0);
    issue(11'h7FF, 64'd3, 64'd4);         collect(0);
    issue(OpMul, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3); collect(0);
`ifdef ALU_SEQ_MUL_EN
    issue(OpMul, 64'd0, 64'd9);           collect(0);
    issue(OpMul, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210); collect(0);
`endif
    issue(OpMovz, 64'h5555, 64'hABCD);    collect(10);

    for (int i = 0; i < 6; i++) begin
      logic [10:0] ops [5];
      ops[0] = OpAdd; ops[1] = OpSub; ops[2] = OpAnd; ops[3] = OpOrr; ops[4] = OpMovz;
      issue(ops[$urandom_range(0, 4)], {$urandom, $urandom}, {$urandom, $urandom});
      collect($urandom_range(0, 2));
    end

    // Abort an in-flight operation with reset.
`ifdef ALU_SEQ_MUL_EN
    issue(OpMul, 64'd77, 64'd99);
    repeat (29) @(posedge clk);
`else
    issue(OpMovz, 64'd0, 64'h77);
    repeat (3) @(posedge clk);
`endif
    #1;
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    check("abort_req_ready", {63'd0, bus_if.req_ready}, 64'd1);
    check("abort_ctrl", {60'd0, bus_if.ALUControl}, 64'hF);
    check("abort_alu_a", bus_if.alu_a, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    issue(OpAdd, 64'd1, 64'd1);           collect(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
